// File: rtl/rf_param.sv
// Parametrised dual-read, single-write register file with a swept synchronous clear,
// write-first bypass and an optional hardwired-zero entry 0.
module rf_param #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  read_enabled,
   input  logic [ADDR_WIDTH-1:0] read_addr_s,
   input  logic [ADDR_WIDTH-1:0] read_addr_t,
   input  logic                  write_enabled,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] outA,
   output logic [DATA_WIDTH-1:0] outB,
   output logic                  busy
);

   localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   clr_idx;
   logic                    clr_en;
   logic                    wr_en;
   logic                    rd_en;
   logic                    busy_nxt;
   logic                    zero_a;
   logic                    zero_b;
   logic                    zero_w;
   logic [DATA_WIDTH-1:0]   rd_a;
   logic [DATA_WIDTH-1:0]   rd_b;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: the sweep ends on the edge that clears the last entry
   always_comb begin
      next_state = state;
      case (state)
         CLEAR:   if (clr_idx == LAST_IDX) next_state = READY;
         READY:   next_state = READY;
         default: next_state = CLEAR;
      endcase
   end

   // Output/control decode; port requests are only honoured in READY
   always_comb begin
      clr_en   = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      busy_nxt = 1'b0;
      case (state)
         CLEAR: begin
            clr_en   = 1'b1;
            busy_nxt = (clr_idx != LAST_IDX);
         end
         READY: begin
            wr_en = write_enabled && !zero_w;
            rd_en = read_enabled;
         end
         default: begin
            clr_en   = 1'b1;
            busy_nxt = 1'b1;
         end
      endcase
   end

   // Read muxes: pre-write array value, write-first bypass, zero entry overrides both
   always_comb begin
      zero_w = (ZERO_REG != 0) && (write_addr == '0);
      zero_a = (ZERO_REG != 0) && (read_addr_s == '0);
      zero_b = (ZERO_REG != 0) && (read_addr_t == '0);

      rd_a = mem[read_addr_s];
      if (write_enabled && (write_addr == read_addr_s)) rd_a = write_data;
      if (zero_a) rd_a = '0;

      rd_b = mem[read_addr_t];
      if (write_enabled && (write_addr == read_addr_t)) rd_b = write_data;
      if (zero_b) rd_b = '0;
   end

   // Sweep counter, busy flag and registered operands
   always_ff @(posedge clock) begin
      if (reset) begin
         clr_idx <= '0;
         busy    <= 1'b1;
         outA    <= '0;
         outB    <= '0;
      end else begin
         busy <= busy_nxt;
         if (clr_en && (clr_idx != LAST_IDX)) clr_idx <= clr_idx + ADDR_WIDTH'(1);
         if (clr_en) begin
            outA <= '0;
            outB <= '0;
         end else if (rd_en) begin
            outA <= rd_a;
            outB <= rd_b;
         end
      end
   end

   // Storage array; no reset, contents are cleared by the sweep instead
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (clr_en) begin
            mem[clr_idx] <= '0;
         end else if (wr_en) begin
            mem[write_addr] <= write_data;
         end
      end
   end

endmodule
